move_scheduler: RTL and testbench

Sequences snake movement. Accepts debounced button codes, queues legal turn requests, and generates the periodic move strobe and current heading consumed by the game-logic/painter block. Its level-dependent tick divider replaces the fixed 2,000,000-cycle divider. It also owns the run/pause/game-over sequencing, so the game-logic block only reacts to `move_tick` and `dir`.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/move_dir_fifo.sv | 59 +++++
 rtl/move_scheduler.sv | 153 +++++++++++++++
 tb/tb_move_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake types: direction codes, scheduler states and turn-legality helpers.
package snake_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_NONE  = 3'd0;
  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_DOWN  = 3'd2;
  localparam dir_t DIR_LEFT  = 3'd3;
  localparam dir_t DIR_RIGHT = 3'd4;
  localparam dir_t DIR_PAUSE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } sched_state_t;

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP))    ||
           ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

  function automatic logic is_move_code(input dir_t c);
    return (c >= DIR_UP) && (c <= DIR_RIGHT);
  endfunction

endpackage

// File: rtl/move_dir_fifo.sv
// Turn queue: synchronous FIFO of directions with head/tail peek, flush, and same-cycle push+pop.
// A push into a full queue is only taken when a pop happens in the same cycle.
module move_dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  dir_t                   din,
  output dir_t                   head,
  output dir_t                   tail,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  dir_t           mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           full;
  logic           empty;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr];
  assign tail = mem[wr_ptr - AW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Snake movement sequencer: run/pause/over FSM, level-scaled move divider, and turn-queue acceptance.
// Outputs are all registered; a queued turn lands in dir on the same edge as move_tick.
module move_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = 2000000,
  parameter int SPEED_STEP = 125000,
  parameter int MAX_LEVEL  = 7,
  parameter int QDEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_valid,
  input  logic [2:0]              btn_code,
  input  logic                    level_up,
  input  logic                    game_over,
  output logic                    move_tick,
  output dir_t                    dir,
  output logic                    paused,
  output logic                    over,
  output logic [2:0]              level,
  output logic [$clog2(QDEPTH):0] q_count
);

  localparam int CW = $clog2(TICK_DIV);

  sched_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period;
  dir_t          dir_d;
  logic [2:0]    level_d;
  logic          tick_d;

  logic          tick_due;
  logic          pop_due;
  logic          pause_req;
  logic          move_req;
  logic          q_full;
  logic          turn_ok;
  dir_t          ref_dir;
  dir_t          q_head;
  dir_t          q_tail;
  logic          q_push;
  logic          q_pop;
  logic          q_flush;

  move_dir_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .din   (btn_code),
    .head  (q_head),
    .tail  (q_tail),
    .count (q_count)
  );

  // Parameter constraint keeps this product inside CW bits.
  assign period   = CW'(TICK_DIV) - CW'(level) * CW'(SPEED_STEP);
  assign tick_due = (state_q == ST_RUN) && (cnt_q >= period - CW'(1));
  assign pop_due  = tick_due && (q_count != '0);

  assign pause_req = btn_valid && (btn_code == DIR_PAUSE);
  assign move_req  = btn_valid && is_move_code(btn_code);
  assign q_full    = (q_count == ($clog2(QDEPTH)+1)'(QDEPTH));
  assign ref_dir   = (q_count != '0) ? q_tail : dir;
  assign turn_ok   = move_req && (btn_code != ref_dir) && !is_reverse(btn_code, ref_dir) &&
                     (!q_full || pop_due);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir;
    level_d = level;
    tick_d  = 1'b0;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (move_req) begin
          dir_d   = btn_code;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (game_over) begin
          state_d = ST_OVER;
          q_flush = 1'b1;
        end else begin
          if (tick_due) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            if (pop_due) begin
              q_pop = 1'b1;
              dir_d = q_head;
            end
          end else if (!pause_req) begin
            // The pause strobe cycle already counts as paused time.
            cnt_d = cnt_q + CW'(1);
          end
          if (pause_req) begin
            state_d = ST_PAUSE;
          end
          q_push = turn_ok;
          if (level_up && (level != 3'(MAX_LEVEL))) begin
            level_d = level + 3'd1;
          end
        end
      end
      ST_PAUSE: begin
        if (game_over) begin
          state_d = ST_OVER;
          q_flush = 1'b1;
        end else begin
          if (pause_req) begin
            state_d = ST_RUN;
          end
          if (level_up && (level != 3'(MAX_LEVEL))) begin
            level_d = level + 3'd1;
          end
        end
      end
      ST_OVER: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dir       <= DIR_NONE;
      level     <= '0;
      move_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir       <= dir_d;
      level     <= level_d;
      move_tick <= tick_d;
    end
  end

  assign paused = (state_q == ST_PAUSE);
  assign over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_move_scheduler.sv
// Directed self-checking bench for move_scheduler at TICK_DIV=20, SPEED_STEP=2, MAX_LEVEL=7, QDEPTH=4.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_valid;
  logic [2:0] btn_code;
  logic       level_up;
  logic       game_over;
  logic       move_tick;
  logic [2:0] dir;
  logic       paused;
  logic       over;
  logic [2:0] level;
  logic [2:0] q_count;

  int errors = 0;
  int checks = 0;
  int tick_cnt = 0;
  int n;

  move_scheduler #(
    .TICK_DIV   (20),
    .SPEED_STEP (2),
    .MAX_LEVEL  (7),
    .QDEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_valid (btn_valid),
    .btn_code  (btn_code),
    .level_up  (level_up),
    .game_over (game_over),
    .move_tick (move_tick),
    .dir       (dir),
    .paused    (paused),
    .over      (over),
    .level     (level),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before this are sampled at the edge; outputs read 1ns after.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (move_tick === 1'b1) tick_cnt++;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic send(input logic [2:0] code);
    btn_valid = 1'b1;
    btn_code  = code;
    cyc();
    btn_valid = 1'b0;
    btn_code  = 3'd0;
  endtask

  task automatic pulse_level();
    level_up = 1'b1;
    cyc();
    level_up = 1'b0;
  endtask

  // Cycles until move_tick is seen; 0 means the bound expired.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (move_tick === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"},   move_tick, 0);
    check({tag, "_dir"},    dir,       0);
    check({tag, "_paused"}, paused,    0);
    check({tag, "_over"},   over,      0);
    check({tag, "_level"},  level,     0);
    check({tag, "_qcount"}, q_count,   0);
  endtask

  initial begin
    rst = 1'b1; btn_valid = 1'b0; btn_code = 3'd0; level_up = 1'b0; game_over = 1'b0;
    cycles(2);
    rst = 1'b0;
    cyc();
    check_reset_outputs("reset");

    // No movement before the first direction; pause/none codes are ignored in IDLE.
    send(3'd5);
    send(3'd0);
    cycles(30);
    check("idle_no_tick", tick_cnt, 0);
    check("idle_not_paused", paused, 0);

    // Start heading right; ticks 20 cycles apart from entry.
    send(3'd4);
    check("start_dir", dir, 4);
    wait_tick(n); check("first_tick_20", n, 20);
    wait_tick(n); check("second_tick_40", n, 20);
    wait_tick(n); check("third_tick_60", n, 20);

    // Legality against reference direction, including reverse of the tail.
    send(3'd3); send(3'd4); send(3'd1); send(3'd1); send(3'd3); send(3'd4);
    check("legal_qcount", q_count, 2);
    wait_tick(n); check("legal_tick_gap", n, 14);
    check("legal_pop1_dir", dir, 1);
    check("legal_pop1_q", q_count, 1);
    wait_tick(n); check("legal_pop2_dir", dir, 3);
    check("legal_pop2_q", q_count, 0);

    // Steer back to heading right.
    send(3'd1); send(3'd4);
    wait_tick(n); wait_tick(n);
    check("steer_dir", dir, 4);

    // Fill the queue; fifth code dropped.
    send(3'd1); send(3'd3); send(3'd1); send(3'd3); send(3'd1);
    check("full_qcount", q_count, 4);
    cycles(14);
    check("full_no_early_tick", move_tick, 0);
    // This strobe lands on the tick-due cycle: pop and push together.
    send(3'd1);
    check("full_coinc_tick", move_tick, 1);
    check("full_coinc_dir", dir, 1);
    check("full_coinc_q", q_count, 4);
    wait_tick(n); check("drain1_dir", dir, 3);
    wait_tick(n); check("drain2_dir", dir, 1);
    wait_tick(n); check("drain3_dir", dir, 3);
    wait_tick(n); check("drain4_dir", dir, 1);
    check("drain_q", q_count, 0);

    // Pause at counter 7, hold 50 cycles, resume leaves 13 cycles.
    cycles(7);
    send(3'd5);
    check("pause_paused", paused, 1);
    tick_cnt = 0;
    cycles(20);
    send(3'd3);
    cycles(29);
    check("pause_no_ticks", tick_cnt, 0);
    check("pause_dropped_q", q_count, 0);
    send(3'd5);
    check("resume_paused", paused, 0);
    wait_tick(n); check("resume_tick_13", n, 13);
    check("resume_dir", dir, 1);

    // Level-up mid-period at counter 15: period 18 applies to the next compare.
    cycles(15);
    pulse_level();
    check("lvl1", level, 1);
    wait_tick(n); check("lvl1_tick_gap", n, 2);
    // Shrink below the running count: counter 17 already past new compare 15.
    cycles(16);
    pulse_level();
    check("lvl2", level, 2);
    wait_tick(n); check("lvl2_overshoot_tick", n, 1);
    wait_tick(n); check("lvl2_period16", n, 16);
    for (int i = 0; i < 7; i++) pulse_level();
    check("lvl_saturate", level, 7);
    wait_tick(n);
    wait_tick(n); check("lvl7_period6_a", n, 6);
    wait_tick(n); check("lvl7_period6_b", n, 6);

    // game_over on the tick-due cycle wins.
    send(3'd3);
    check("over_prefill_q", q_count, 1);
    cycles(4);
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    check("over_no_tick", move_tick, 0);
    check("over_flag", over, 1);
    check("over_flush_q", q_count, 0);
    check("over_dir_frozen", dir, 1);

    tick_cnt = 0;
    send(3'd5); send(3'd4); send(3'd2);
    pulse_level();
    cycles(20);
    check("over_ignore_ticks", tick_cnt, 0);
    check("over_ignore_paused", paused, 0);
    check("over_ignore_level", level, 7);
    check("over_ignore_dir", dir, 1);
    check("over_ignore_q", q_count, 0);
    check("over_stays", over, 1);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_outputs("rerst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
